// File: rtl/multdiv_unit_if.sv
// Operand/start/result bundle between the DX/XM latches and the multiply/divide unit.
// master = pipeline side, slave = multdiv_unit.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             multdiv_busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, multdiv_busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, multdiv_busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit beside the ALU; busy stalls the front of the pipe.
// Build option MULTDIV_RADIX4_EN: radix-4 Booth multiply (2 bits/cycle); divide is unchanged.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// MUL   | multiply iterations
// DIV   | restoring-divide iterations, one quotient bit per edge
// DONE  | iterations finished; next edge writes result and pulses RDY
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
`ifdef MULTDIV_RADIX4_EN
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
`else
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);
`endif
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            op_div;
  logic            neg;
  logic            div_zero;
  logic            div_ovf;
  logic [WIDTH-1:0] opb_mag;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             start;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;

  assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
  assign a_mag_in = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign b_mag_in = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  // restoring divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_mag};

  logic [2*WIDTH-1:0] prod;
  logic               mul_exc;
  logic [WIDTH-1:0]   div_q;

`ifdef MULTDIV_RADIX4_EN
  logic [2*WIDTH-1:0] booth_acc;
  logic [2*WIDTH-1:0] booth_cand;
  logic [WIDTH-1:0]   booth_plier;
  logic               booth_prev;
  logic [2*WIDTH-1:0] booth_pp;

  always_comb begin
    booth_pp = '0;
    case ({booth_plier[1:0], booth_prev})
      3'b001, 3'b010: booth_pp = booth_cand;
      3'b011:         booth_pp = booth_cand << 1;
      3'b100:         booth_pp = -(booth_cand << 1);
      3'b101, 3'b110: booth_pp = -booth_cand;
      default:        booth_pp = '0;
    endcase
  end

  assign prod = booth_acc;
`else
  logic [WIDTH-1:0]   opa_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_mag;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa_mag} : {(WIDTH+1){1'b0}});
  assign prod_mag = {acc_hi, acc_lo};
  assign prod     = neg ? -prod_mag : prod_mag;
`endif

  assign mul_exc = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
  assign div_q   = neg ? -acc_lo : acc_lo;

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      op_div             <= 1'b0;
      neg                <= 1'b0;
      div_zero           <= 1'b0;
      div_ovf            <= 1'b0;
      opb_mag            <= '0;
      acc_hi             <= '0;
      acc_lo             <= '0;
`ifdef MULTDIV_RADIX4_EN
      booth_acc          <= '0;
      booth_cand         <= '0;
      booth_plier        <= '0;
      booth_prev         <= 1'b0;
`else
      opa_mag            <= '0;
`endif
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.multdiv_busy   <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      if (start) begin
        // a start in any state, including mid-operation, restarts from scratch
        cnt              <= '0;
        bus.multdiv_busy <= 1'b1;
        neg              <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        div_zero         <= bus.data_operandB == '0;
        div_ovf          <= (bus.data_operandA == MIN_NEG) && (bus.data_operandB == '1);
        opb_mag          <= b_mag_in;
        acc_hi           <= '0;
        if (bus.ctrl_MULT) begin
          state  <= MUL;
          op_div <= 1'b0;
          acc_lo <= b_mag_in;
`ifdef MULTDIV_RADIX4_EN
          booth_acc   <= '0;
          booth_cand  <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
          booth_plier <= bus.data_operandB;
          booth_prev  <= 1'b0;
`else
          opa_mag     <= a_mag_in;
`endif
        end else begin
          state  <= DIV;
          op_div <= 1'b1;
          acc_lo <= a_mag_in;
        end
      end else begin
        case (state)
          MUL: begin
`ifdef MULTDIV_RADIX4_EN
            booth_acc   <= booth_acc + booth_pp;
            booth_cand  <= booth_cand << 2;
            booth_plier <= booth_plier >> 2;
            booth_prev  <= booth_plier[1];
`else
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif
            if (cnt == MUL_LAST) state <= DONE;
            else                 cnt   <= cnt + 1'b1;
          end
          DIV: begin
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
            if (cnt == DIV_LAST) state <= DONE;
            else                 cnt   <= cnt + 1'b1;
          end
          DONE: begin
            state              <= IDLE;
            bus.multdiv_busy   <= 1'b0;
            bus.data_resultRDY <= 1'b1;
            if (!op_div) begin
              bus.data_result    <= prod[WIDTH-1:0];
              bus.data_exception <= mul_exc;
            end else if (div_zero) begin
              bus.data_result    <= '0;
              bus.data_exception <= 1'b1;
            end else if (div_ovf) begin
              bus.data_result    <= MIN_NEG;
              bus.data_exception <= 1'b1;
            end else begin
              bus.data_result    <= div_q;
              bus.data_exception <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
